// File: rtl/match_controller.sv
// match_controller
//   Sequencing controller for the card-comparison datapath. Collects one
//   4-bit card from each player per round over valid/ready handshakes,
//   presents the latched pair to the external compare block, samples its
//   2-bit result for one EVAL cycle, and keeps scores, round count and the
//   final match winner.
//
// Build option:
//   MATCH_CTRL_DRAW_REPLAY_EN - when defined, a drawn round (01 or illegal
//   00) is replayed and does not advance round_num; round_valid still
//   pulses with round_result = 01.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start                      begin a match (IDLE or DONE only)
//   p1_valid/p1_card/p1_ready  player 1 card handshake
//   p2_valid/p2_card/p2_ready  player 2 card handshake
//   cmp_p1_card, cmp_p2_card   latched cards to compare block
//   cmp_result                 compare output: 01 draw, 10 P1, 11 P2
//   round_valid                one-cycle pulse when a round resolves
//   round_result               result of last resolved round (held)
//   round_num                  rounds counted so far
//   p1_score, p2_score         rounds won per player
//   busy                       high in COLLECT or EVAL
//   match_done                 high in DONE
//   match_winner               01 draw, 10 P1, 11 P2; 00 unless DONE
module match_controller #(
  parameter int MAX_ROUNDS = 5,
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               p1_valid,
  input  logic [3:0]         p1_card,
  output logic               p1_ready,
  input  logic               p2_valid,
  input  logic [3:0]         p2_card,
  output logic               p2_ready,
  output logic [3:0]         cmp_p1_card,
  output logic [3:0]         cmp_p2_card,
  input  logic [1:0]         cmp_result,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] round_num,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         match_winner
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EVAL    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_P1   = 2'b10;
  localparam logic [1:0] RES_P2   = 2'b11;

  localparam logic [SCORE_W-1:0] LP_WIN = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] LP_MAX = SCORE_W'(MAX_ROUNDS);

  logic [1:0]         r_state;
  logic [3:0]         r_p1_card;
  logic [3:0]         r_p2_card;
  logic               r_p1_have;
  logic               r_p2_have;
  logic               r_round_valid;
  logic [1:0]         r_round_result;
  logic [SCORE_W-1:0] r_round_num;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;

  logic               w_collect;
  logic               w_eval;
  logic               w_done;
  logic               w_p1_hs;
  logic               w_p2_hs;
  logic               w_both;
  logic               w_p1_win;
  logic               w_p2_win;
  logic               w_draw;
  logic               w_count_round;
  logic               w_end;
  logic [1:0]         w_result;
  logic [SCORE_W-1:0] w_p1_score_nx;
  logic [SCORE_W-1:0] w_p2_score_nx;
  logic [SCORE_W-1:0] w_round_num_nx;

  assign w_collect = (r_state == S_COLLECT);
  assign w_eval    = (r_state == S_EVAL);
  assign w_done    = (r_state == S_DONE);

  always_comb begin
    w_p1_hs  = w_collect & ~r_p1_have & p1_valid;
    w_p2_hs  = w_collect & ~r_p2_have & p2_valid;
    // Leave COLLECT on the edge that completes the pair, including the
    // case where both players hand over in the same cycle.
    w_both   = (r_p1_have | w_p1_hs) & (r_p2_have | w_p2_hs);

    w_p1_win = (cmp_result == RES_P1);
    w_p2_win = (cmp_result == RES_P2);
    // Illegal 00 folds into a draw.
    w_draw   = ~(w_p1_win | w_p2_win);
    w_result = w_draw ? RES_DRAW : cmp_result;

`ifdef MATCH_CTRL_DRAW_REPLAY_EN
    w_count_round = ~w_draw;
`else
    w_count_round = 1'b1;
`endif

    w_p1_score_nx  = r_p1_score + SCORE_W'(w_p1_win);
    w_p2_score_nx  = r_p2_score + SCORE_W'(w_p2_win);
    w_round_num_nx = r_round_num + SCORE_W'(w_count_round);
    w_end = (w_p1_score_nx == LP_WIN) || (w_p2_score_nx == LP_WIN) ||
            (w_round_num_nx == LP_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_p1_card      <= '0;
      r_p2_card      <= '0;
      r_p1_have      <= 1'b0;
      r_p2_have      <= 1'b0;
      r_round_valid  <= 1'b0;
      r_round_result <= '0;
      r_round_num    <= '0;
      r_p1_score     <= '0;
      r_p2_score     <= '0;
    end else begin
      r_round_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_p1_card   <= '0;
            r_p2_card   <= '0;
            r_p1_have   <= 1'b0;
            r_p2_have   <= 1'b0;
            r_round_num <= '0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_state     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_p1_hs) begin
            r_p1_card <= p1_card;
            r_p1_have <= 1'b1;
          end
          if (w_p2_hs) begin
            r_p2_card <= p2_card;
            r_p2_have <= 1'b1;
          end
          if (w_both) r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_p1_score     <= w_p1_score_nx;
          r_p2_score     <= w_p2_score_nx;
          r_round_num    <= w_round_num_nx;
          r_round_result <= w_result;
          r_round_valid  <= 1'b1;
          r_p1_have      <= 1'b0;
          r_p2_have      <= 1'b0;
          r_state        <= w_end ? S_DONE : S_COLLECT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p1_ready     = w_collect & ~r_p1_have;
  assign p2_ready     = w_collect & ~r_p2_have;
  assign cmp_p1_card  = r_p1_card;
  assign cmp_p2_card  = r_p2_card;
  assign round_valid  = r_round_valid;
  assign round_result = r_round_result;
  assign round_num    = r_round_num;
  assign p1_score     = r_p1_score;
  assign p2_score     = r_p2_score;
  assign busy         = w_collect | w_eval;
  assign match_done   = w_done;
  assign match_winner = !w_done                   ? 2'b00  :
                        (r_p1_score > r_p2_score) ? RES_P1 :
                        (r_p1_score < r_p2_score) ? RES_P2 : RES_DRAW;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a round scoreboard.
module tb_match_controller;

  localparam int MAXR = 5;
  localparam int WIN  = 3;
  localparam int SW   = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          p1_valid;
  logic [3:0]    p1_card;
  logic          p1_ready;
  logic          p2_valid;
  logic [3:0]    p2_card;
  logic          p2_ready;
  logic [3:0]    cmp_p1_card;
  logic [3:0]    cmp_p2_card;
  logic [1:0]    cmp_result;
  logic          round_valid;
  logic [1:0]    round_result;
  logic [SW-1:0] round_num;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;
  logic          busy;
  logic          match_done;
  logic [1:0]    match_winner;

  match_controller #(
    .MAX_ROUNDS(MAXR),
    .WIN_TARGET(WIN),
    .SCORE_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .p1_valid    (p1_valid),
    .p1_card     (p1_card),
    .p1_ready    (p1_ready),
    .p2_valid    (p2_valid),
    .p2_card     (p2_card),
    .p2_ready    (p2_ready),
    .cmp_p1_card (cmp_p1_card),
    .cmp_p2_card (cmp_p2_card),
    .cmp_result  (cmp_result),
    .round_valid (round_valid),
    .round_result(round_result),
    .round_num   (round_num),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .busy        (busy),
    .match_done  (match_done),
    .match_winner(match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    res;
    logic [SW-1:0] p1;
    logic [SW-1:0] p2;
    logic [SW-1:0] rn;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

`ifdef MATCH_CTRL_DRAW_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  // Reference model state
  int e_p1 = 0;
  int e_p2 = 0;
  int e_rn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({p1_ready, p2_ready, cmp_p1_card, cmp_p2_card, round_valid,
                round_result, round_num, p1_score, p2_score, busy,
                match_done, match_winner});
  endfunction

  function automatic bit e_done();
    return (e_p1 == WIN) || (e_p2 == WIN) || (e_rn == MAXR);
  endfunction

  function automatic logic [1:0] e_winner();
    if (!e_done()) return 2'b00;
    if (e_p1 > e_p2) return 2'b10;
    if (e_p1 < e_p2) return 2'b11;
    return 2'b01;
  endfunction

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    e_p1 = 0;
    e_p2 = 0;
    e_rn = 0;
  endtask

  // Scoreboard consumer: every round_valid pulse must match the oldest entry.
  always @(negedge clk) begin
    if (round_valid) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_round_valid observed=%0d expected=%0d", sb.size(), 1);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rv_result", 32'(round_result), 32'(e.res));
        chk("rv_p1_score", 32'(p1_score), 32'(e.p1));
        chk("rv_p2_score", 32'(p2_score), 32'(e.p2));
        chk("rv_round_num", 32'(round_num), 32'(e.rn));
      end
    end
  end

  // Called at posedge+1 in COLLECT. P1 offers now; P2 offers after d2 cycles.
  task automatic play_round(input logic [3:0] c1, input logic [3:0] c2,
                            input logic [1:0] res, input int unsigned d2);
    exp_t e;
    bit   draw;
    draw = !(res == 2'b10 || res == 2'b11);
    if (res == 2'b10) e_p1++;
    if (res == 2'b11) e_p2++;
    if (!(REPLAY && draw)) e_rn++;
    e.res = draw ? 2'b01 : res;
    e.p1  = SW'(e_p1);
    e.p2  = SW'(e_p2);
    e.rn  = SW'(e_rn);
    sb.push_back(e);

    p1_card    = c1;
    p1_valid   = 1'b1;
    p2_card    = c2;
    p2_valid   = (d2 == 0);
    cmp_result = res;
    cyc();
    p1_valid = 1'b0;
    for (int unsigned i = 0; i < d2; i++) begin
      chk("wait_p1_ready", 32'(p1_ready), 32'd0);
      chk("wait_p2_ready", 32'(p2_ready), 32'd1);
      if (i == d2 - 1) p2_valid = 1'b1;
      cyc();
    end
    p2_valid = 1'b0;
    // EVAL cycle
    chk("eval_readies", 32'({p1_ready, p2_ready}), 32'd0);
    chk("eval_busy", 32'(busy), 32'd1);
    chk("eval_cards", 32'({cmp_p1_card, cmp_p2_card}), 32'({c1, c2}));
    cyc();
    chk("post_done", 32'(match_done), 32'(e_done()));
    chk("post_winner", 32'(match_winner), 32'(e_winner()));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    p1_valid   = 1'b0;
    p2_valid   = 1'b0;
    p1_card    = '0;
    p2_card    = '0;
    cmp_result = 2'b00;

    // Reset state
    repeat (2) cyc();
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_outputs", all_outs(), 32'd0);

    // Start -> COLLECT with both readies up
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_readies", 32'({p1_ready, p2_ready}), 32'b11);

    // Simultaneous handshake, P1 wins
    play_round(4'b0010, 4'b0001, 2'b10, 0);
    // Staggered: P2 offers three cycles after P1, P2 wins
    play_round(4'b0100, 4'b1000, 2'b11, 3);

    // start in COLLECT is ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_start_scores", 32'({p1_score, p2_score}), 32'({3'd1, 3'd1}));
    chk("ign_start_round", 32'(round_num), 32'd2);
    chk("ign_start_busy", 32'(busy), 32'd1);

    // P1 win, illegal 00 (draw), P1 win -> P1 reaches 3
    play_round(4'b0101, 4'b0011, 2'b10, 0);
    play_round(4'b0110, 4'b0110, 2'b00, 1);
    play_round(4'b1001, 4'b0001, 2'b10, 0);

    // DONE: no more cards accepted, outputs held
    p1_valid = 1'b1;
    p2_valid = 1'b1;
    p1_card  = 4'hF;
    p2_card  = 4'hE;
    repeat (2) cyc();
    chk("done_readies", 32'({p1_ready, p2_ready}), 32'd0);
    chk("done_cards", 32'({cmp_p1_card, cmp_p2_card}), 32'h91);
    chk("done_hold", 32'(match_done), 32'd1);
    p1_valid = 1'b0;
    p2_valid = 1'b0;

    // Restart from DONE, P1 wins three straight
    do_start();
    chk("restart_clear", 32'({round_num, p1_score, p2_score, cmp_p1_card, cmp_p2_card}), 32'd0);
    for (int unsigned r = 0; r < 3; r++) play_round(4'b1100, 4'b0011, 2'b10, 0);
    chk("three_round_num", 32'(round_num), 32'd3);

    // Five draws
    do_start();
    for (int unsigned r = 0; r < 5; r++) play_round(4'b0111, 4'b0111, 2'b01, 0);
    chk("draws_round_num", 32'(round_num), REPLAY ? 32'd0 : 32'd5);
    chk("draws_busy", 32'(busy), REPLAY ? 32'd1 : 32'd0);

    // Reset during EVAL aborts the round; no round_valid is expected
    do_start();
    p1_card  = 4'b0011;
    p2_card  = 4'b0010;
    p1_valid = 1'b1;
    p2_valid = 1'b1;
    cmp_result = 2'b10;
    cyc();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    chk("pre_abort_eval", 32'({busy, p1_ready, p2_ready}), 32'b100);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", all_outs(), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("abort_idle", all_outs(), 32'd0);

    // Clean match after abort
    do_start();
    chk("clean_start", 32'({busy, round_num, p1_score, p2_score}), 32'h200);
    play_round(4'b0001, 4'b0010, 2'b11, 0);

    cyc();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Sequencing controller for the card-comparison datapath. Collects one 4-bit hand card from each player per round through valid/ready handshakes, presents the card pair to the external `compare` block, samples its 2-bit match result, and keeps per-player scores and the round count. Declares a match winner when a player reaches the win target or the round limit is hit. Sits between the player input logic and the `compare` instance.

## Interface
- `MAX_ROUNDS`, 5: rounds per match (1..2^SCORE_W-1)
- `WIN_TARGET`, 3: score that ends the match early (1..MAX_ROUNDS)
- `SCORE_W`, 3: width of score and round counters
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  start a new match; honoured only in IDLE or DONE
- `p1_valid` / `p2_valid`  in  1  player card offered
- `p1_card` / `p2_card`  in  4  offered card value
- `p1_ready` / `p2_ready`  out  1  controller accepts card this cycle
- `cmp_p1_card` / `cmp_p2_card`  out  4  latched cards driven to `compare`
- `cmp_result`  in  2  `compare` output: 01 draw, 10 P1 wins, 11 P2 wins
- `round_valid`  out  1  one-cycle pulse, round resolved
- `round_result`  out  2  result of last resolved round (held)
- `round_num`  out  SCORE_W  rounds counted so far
- `p1_score` / `p2_score`  out  SCORE_W  rounds won
- `busy`  out  1  high in COLLECT or EVAL
- `match_done`  out  1  high in DONE
- `match_winner`  out  2  01 draw, 10 P1, 11 P2; 00 unless DONE

## Operation
- States: IDLE, COLLECT, EVAL, DONE.
- IDLE: readies low. `start` → clear scores, `round_num`, card latches, have-flags; go COLLECT.
- COLLECT: `pN_ready = !pN_have`. Handshake (`pN_valid & pN_ready`) latches `pN_card`, sets `pN_have`. Players are independent; both may handshake in the same cycle. Once both flags are set, or the last missing flag is set on this edge, go EVAL.
- EVAL (exactly one cycle): readies low. `cmp_result` is sampled at the end of the cycle.
  - 10 increments `p1_score`, 11 increments `p2_score`, 01 increments neither.
  - 00 is illegal and is treated as a draw.
  - Register `round_result`, pulse `round_valid`, increment `round_num`, clear both have-flags.
  - Next state is DONE if either updated score equals `WIN_TARGET` or updated `round_num` equals `MAX_ROUNDS`. Otherwise it is COLLECT.
- DONE: `match_done`=1. `match_winner` = 10 if `p1_score`>`p2_score`, 11 if less, 01 if equal. Scores and result hold. `start` begins a new match exactly as from IDLE.
- `start` is ignored in COLLECT and EVAL.
- `cmp_pN_card` always equals the latched card registers.
- Counters never wrap, because of the parameter limits.

## Timing
- Reset values (async, immediate): state IDLE; all outputs 0; card latches 0.
- `start` sampled at edge t → COLLECT and readies high from t.
- Final handshake at edge k → EVAL during cycle k..k+1. At edge k+1: scores, `round_num`, `round_result` update and `round_valid`=1 for exactly cycle k+1..k+2.
- Next COLLECT readies are high from k+1, so back-to-back rounds are possible.
- `match_done` and `match_winner` are valid from edge k+1 of the deciding round.
- `rst_n` low mid-round: the match is aborted, the in-flight round is discarded and no `round_valid` is produced.

## Configuration
- `MATCH_CTRL_DRAW_REPLAY_EN` defined:
  - A draw (01 or 00) does not increment `round_num`; the round is replayed.
  - `round_valid` still pulses with `round_result`=01.
- Undefined: draws count toward `MAX_ROUNDS`, as described in Operation.

## Test plan
- Reset then `start`; P1 offers 0010, P2 offers 0001 in the same cycle; `compare` returns 10 → one cycle later `round_valid`=1, `round_result`=10, `p1_score`=1, `round_num`=1.
- P1 offers 0100 three cycles before P2 offers 1000 → `p1_ready` low while waiting for P2, EVAL only after the P2 handshake, result 11, `p2_score`+1.
- Defaults; P1 wins three straight rounds → DONE after round 3, `match_winner`=10, `round_num`=3, further valids not accepted.
- Default parameters, 5 draws (0111 vs 0111):
  - Macro undefined → DONE after round 5, `match_winner`=01.
  - Macro defined → `round_num` stays 0, still COLLECT.
- Assert `rst_n` during EVAL → all outputs 0 immediately, no `round_valid`; new `start` gives a clean match.
- `start` pulsed in COLLECT → ignored, scores unchanged.
